activity_led_bank: RTL

Parametrised multi-channel activity indicator for board status LEDs. It generalises the single "CPU running" LED stretcher in the FPGA top level to NUM_CH channels, such as CPU running, SPI chip-select activity and UART traffic. Each channel has a runtime-selectable display mode: windowed sample, retriggerable stretch, blink-while-active, or direct. The block sits in the board top level, clocked by sys_clk, between SoC status signals and the LED pins.

---
 rtl/board_io_pkg.sv | 20 ++
 rtl/activity_channel.sv | 98 +++++++++
 rtl/activity_led_bank.sv | 111 +++++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// -----------------------------------------------------------------------------
// board_io_pkg
// Shared definitions for the board status LED logic: the per-channel display
// mode encoding and the default widths used by activity_led_bank.
// -----------------------------------------------------------------------------
package board_io_pkg;

    // Per-channel display modes (two bits per channel on the mode bus)
    localparam logic [1:0] MODE_SAMPLED = 2'b00;
    localparam logic [1:0] MODE_STRETCH = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_DIRECT  = 2'b11;

    // Default geometry
    localparam int unsigned DEF_NUM_CH       = 32'd4;
    localparam int unsigned DEF_WINDOW_BITS  = 32'd20;
    localparam int unsigned DEF_STRETCH_BITS = 32'd20;
    localparam int unsigned DEF_SYNC_STAGES  = 32'd2;

endpackage : board_io_pkg

// File: rtl/activity_channel.sv
// -----------------------------------------------------------------------------
// activity_channel
// One LED channel. The window tracker (seen / win_active) and the retriggerable
// stretch counter run continuously regardless of mode; mode only chooses which
// of them drives the registered logical LED value.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   act_s        - synchronised activity level
//   tick         - one-cycle pulse at the last cycle of each window
//   blink_phase  - high during the first half of each window
//   mode         - display mode (board_io_pkg MODE_*)
//   enable       - global enable; 0 forces the LED off
//   led          - logical LED value (1 = lit), registered
// -----------------------------------------------------------------------------
module activity_channel
    import board_io_pkg::*;
#(
    parameter int unsigned STRETCH_BITS = DEF_STRETCH_BITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       act_s,
    input  logic       tick,
    input  logic       blink_phase,
    input  logic [1:0] mode,
    input  logic       enable,
    output logic       led
);

    localparam logic [STRETCH_BITS-1:0] STRETCH_MAX  = {STRETCH_BITS{1'b1}};
    localparam logic [STRETCH_BITS-1:0] STRETCH_ZERO = {STRETCH_BITS{1'b0}};
    localparam logic [STRETCH_BITS-1:0] STRETCH_ONE  = STRETCH_BITS'(1);

    logic                    seen_q,       seen_d;
    logic                    win_active_q, win_active_d;
    logic [STRETCH_BITS-1:0] stretch_q,    stretch_d;
    logic                    led_q,        led_d;
    logic                    led_sel;

    // Next-state logic for the trackers and the mode-selected LED value
    always_comb begin
        seen_d       = seen_q | act_s;
        win_active_d = win_active_q;
        stretch_d    = stretch_q;
        led_sel      = 1'b0;
        led_d        = 1'b0;

        // Activity in the tick cycle belongs to the window that is closing.
        if (tick) begin
            win_active_d = seen_q | act_s;
            seen_d       = 1'b0;
        end else begin
            win_active_d = win_active_q;
        end

        // Reload has priority over the decrement, so a pulse at count 1 reloads.
        if (act_s) begin
            stretch_d = STRETCH_MAX;
        end else if (stretch_q != STRETCH_ZERO) begin
            stretch_d = stretch_q - STRETCH_ONE;
        end else begin
            stretch_d = STRETCH_ZERO;
        end

        case (mode)
            MODE_SAMPLED: led_sel = win_active_q;
            MODE_STRETCH: led_sel = act_s | (stretch_q != STRETCH_ZERO);
            MODE_BLINK:   led_sel = win_active_q & blink_phase;
            MODE_DIRECT:  led_sel = act_s;
            default:      led_sel = 1'b0;
        endcase

        if (enable) begin
            led_d = led_sel;
        end else begin
            led_d = 1'b0;
        end
    end

    // Tracker and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q       <= 1'b0;
            win_active_q <= 1'b0;
            stretch_q    <= STRETCH_ZERO;
            led_q        <= 1'b0;
        end else begin
            seen_q       <= seen_d;
            win_active_q <= win_active_d;
            stretch_q    <= stretch_d;
            led_q        <= led_d;
        end
    end

    assign led = led_q;

endmodule : activity_channel

// File: rtl/activity_led_bank.sv
// -----------------------------------------------------------------------------
// activity_led_bank
// Multi-channel activity indicator for board status LEDs. Holds the input
// synchronisers, the shared window prescaler and the pin polarity; each
// channel's display logic lives in activity_channel.
//
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   act_in  - raw activity level per channel
//   mode    - per-channel mode, bits [2i+1:2i] for channel i
//   enable  - global LED enable
//   led     - LED pin drive (inverted when LED_ACTIVE_LOW = 1)
// -----------------------------------------------------------------------------
module activity_led_bank
    import board_io_pkg::*;
#(
    parameter int unsigned NUM_CH         = DEF_NUM_CH,
    parameter int unsigned WINDOW_BITS    = DEF_WINDOW_BITS,
    parameter int unsigned STRETCH_BITS   = DEF_STRETCH_BITS,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     act_in,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic                  enable,
    output logic [NUM_CH-1:0]     led
);

    localparam logic [WINDOW_BITS-1:0] PRESC_ONE  = WINDOW_BITS'(1);
    localparam logic [WINDOW_BITS-1:0] PRESC_ZERO = {WINDOW_BITS{1'b0}};

    logic [NUM_CH-1:0]      act_s;
    logic [WINDOW_BITS-1:0] presc_q, presc_d;
    logic                   tick;
    logic                   blink_phase;
    logic [NUM_CH-1:0]      led_logic;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign act_s = act_in;
        end else begin : g_sync
            logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
            logic [NUM_CH-1:0] sync_d [SYNC_STAGES];

            // Shift the raw activity through the synchroniser chain
            always_comb begin
                sync_d[0] = act_in;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // Synchroniser flops
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= {NUM_CH{1'b0}};
                    end
                end else begin
                    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= sync_d[i];
                    end
                end
            end

            assign act_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Free-running down-counter; the 0 -> all-ones wrap is the window boundary
    always_comb begin
        presc_d = presc_q - PRESC_ONE;
    end

    // Prescaler register, starts at all-ones so the first tick is 2^W-1 edges out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= {WINDOW_BITS{1'b1}};
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick        = (presc_q == PRESC_ZERO);
    assign blink_phase = presc_q[WINDOW_BITS-1];

    generate
        for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
            activity_channel #(
                .STRETCH_BITS (STRETCH_BITS)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .act_s       (act_s[g]),
                .tick        (tick),
                .blink_phase (blink_phase),
                .mode        (mode[2*g +: 2]),
                .enable      (enable),
                .led         (led_logic[g])
            );
        end
    endgenerate

    // Pin polarity is a fixed inversion of the registered logical value, so the
    // pins still go to the off level asynchronously in reset.
    assign led = led_logic ^ {NUM_CH{LED_ACTIVE_LOW}};

endmodule : activity_led_bank
